// File: rtl/slv_stream_feeder.sv
// Byte-stream to DW-bit word packer feeding one accelerator slave port.
// Optional SLV_FEEDER_PREFETCH_EN adds a second pack buffer for back-to-back words.
module slv_stream_feeder #(
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       cfg_mode,
    input  logic [7:0]       cfg_proc_val,
    input  logic [CNT_W-1:0] cfg_words,
    input  logic [7:0]       pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [1:0]       slv_mode,
    output logic [7:0]       slv_proc_valid,
    output logic [DW-1:0]    slv_data,
    output logic             slv_data_valid,
    input  logic             slv_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PACK = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    buf_q, buf_d;
    logic [DW-1:0]    data_d;
    logic [1:0]       mode_d;
    logic [7:0]       proc_d;
    logic             pix_ready_d, valid_d, busy_d, done_d;
    logic             take, word_done;
`ifdef SLV_FEEDER_PREFETCH_EN
    logic             full_q, full_d;
    logic [CNT_W-1:0] unpk_q, unpk_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            idx_q          <= '0;
            buf_q          <= '0;
            slv_data       <= '0;
            slv_mode       <= '0;
            slv_proc_valid <= '0;
            pix_ready      <= 1'b0;
            slv_data_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SLV_FEEDER_PREFETCH_EN
            full_q         <= 1'b0;
            unpk_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            idx_q          <= idx_d;
            buf_q          <= buf_d;
            slv_data       <= data_d;
            slv_mode       <= mode_d;
            slv_proc_valid <= proc_d;
            pix_ready      <= pix_ready_d;
            slv_data_valid <= valid_d;
            busy           <= busy_d;
            done           <= done_d;
`ifdef SLV_FEEDER_PREFETCH_EN
            full_q         <= full_d;
            unpk_q         <= unpk_d;
`endif
        end
    end

    // Next state, pixel packing and next output values
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        data_d  = slv_data;
        mode_d  = slv_mode;
        proc_d  = slv_proc_valid;
`ifdef SLV_FEEDER_PREFETCH_EN
        full_d  = full_q;
        unpk_d  = unpk_q;
`endif
        take      = pix_valid && pix_ready;
        word_done = take && (idx_q == LAST_IDX);

        for (int unsigned b = 0; b < NB; b++) begin
            if (take && (idx_q == IW'(b))) buf_d[b*8 +: 8] = pix_in;
        end
        if (take) idx_d = word_done ? '0 : idx_q + IW'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = cfg_mode;
                    proc_d  = cfg_proc_val;
                    rem_d   = cfg_words;
                    idx_d   = '0;
                    buf_d   = '0;
`ifdef SLV_FEEDER_PREFETCH_EN
                    unpk_d  = cfg_words;
                    full_d  = 1'b0;
`endif
                    state_d = (cfg_words != '0) ? PACK : DONE;
                end
            end
            PACK: begin
                if (word_done) begin
                    data_d  = buf_d;
                    state_d = SEND;
`ifdef SLV_FEEDER_PREFETCH_EN
                    unpk_d  = unpk_q - CNT_W'(1);
`endif
                end
            end
            SEND: begin
`ifdef SLV_FEEDER_PREFETCH_EN
                if (word_done) begin
                    full_d = 1'b1;
                    unpk_d = unpk_q - CNT_W'(1);
                end
`endif
                if (slv_ready) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
`ifdef SLV_FEEDER_PREFETCH_EN
                    else if (full_d) begin
                        data_d = buf_d;
                        full_d = 1'b0;
                    end
`endif
                    else begin
                        state_d = PACK;
                    end
                end
            end
            DONE: begin
                // A zero-length frame enters DONE with done low, so it pulses one cycle later
                if (done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        valid_d     = (state_d == SEND);
        done_d      = (state_d == DONE) && (state_q != IDLE) && !done;
        pix_ready_d = (state_d == PACK);
`ifdef SLV_FEEDER_PREFETCH_EN
        if ((state_d == SEND) && !full_d && (unpk_d != '0)) pix_ready_d = 1'b1;
`endif
    end

endmodule

// File: tb/tb_slv_stream_feeder.sv
// Self-checking bench for slv_stream_feeder: vector table, directed corner cases
// and random frames checked against a transaction-level pixel/word model.
module tb_slv_stream_feeder;

    logic        clk, rst_n, start;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_proc_val;
    logic [15:0] cfg_words;
    logic [7:0]  pix_in;
    logic        pix_valid, pix_ready;
    logic [1:0]  slv_mode;
    logic [7:0]  slv_proc_valid;
    logic [31:0] slv_data;
    logic        slv_data_valid, slv_ready, busy, done;

    slv_stream_feeder #(.DW(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_proc_val(cfg_proc_val), .cfg_words(cfg_words), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .slv_mode(slv_mode),
        .slv_proc_valid(slv_proc_valid), .slv_data(slv_data),
        .slv_data_valid(slv_data_valid), .slv_ready(slv_ready), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0]  mode;
        logic [7:0]  proc_val;
        logic [7:0]  p0, p1, p2, p3;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    logic [7:0]  byteq[$];
    logic [31:0] wordq[$];
    int  xfer, frame_words, pix_acc;
    bit  mon_en;
    logic        p_valid, p_ready, p_pv, p_pr, p_done;
    logic [31:0] p_data;
    logic [1:0]  p_mode;
    logic [7:0]  p_proc, p_pix;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one cycle, then compare the DUT against the pixel/word model
    task automatic tick();
        logic [31:0] w;
        p_valid = slv_data_valid; p_ready = slv_ready; p_data = slv_data;
        p_mode = slv_mode; p_proc = slv_proc_valid; p_pv = pix_valid;
        p_pr = pix_ready; p_pix = pix_in; p_done = done;
        @(negedge clk);
        if (!mon_en) return;
        if (p_pv && p_pr) begin
            pix_acc++;
            byteq.push_back(p_pix);
            if (byteq.size() == 4) begin
                w = {byteq[3], byteq[2], byteq[1], byteq[0]};
                wordq.push_back(w);
                byteq.delete();
            end
        end
        if (p_valid && p_ready) begin
            xfer++;
            if (wordq.size() == 0) chk("xfer_unexpected", 64'(xfer), 64'(0));
            else begin
                w = wordq.pop_front();
                chk("xfer_data", 64'(p_data), 64'(w));
            end
            if (xfer == frame_words) chk("done_after_last", 64'(done), 64'(1));
`ifndef SLV_FEEDER_PREFETCH_EN
            else begin
                chk("gap_after_word", 64'(slv_data_valid), 64'(0));
                chk("pix_ready_after_xfer", 64'(pix_ready), 64'(1));
            end
`endif
        end else if (p_valid) begin
            chk("hold_valid", 64'(slv_data_valid), 64'(1));
            chk("hold_data", 64'(slv_data), 64'(p_data));
            chk("hold_mode", 64'(slv_mode), 64'(p_mode));
            chk("hold_proc", 64'(slv_proc_valid), 64'(p_proc));
        end
`ifndef SLV_FEEDER_PREFETCH_EN
        if (slv_data_valid) chk("pix_ready_in_send", 64'(pix_ready), 64'(0));
`endif
        if (p_done) chk("done_one_cycle", 64'(done), 64'(0));
        if (done) chk("done_xfer_count", 64'(xfer), 64'(frame_words));
    endtask

    task automatic start_frame(input int words, input logic [1:0] m, input logic [7:0] pv);
        byteq.delete(); wordq.delete();
        xfer = 0; pix_acc = 0; frame_words = words;
        start = 1'b1; cfg_words = 16'(words); cfg_mode = m; cfg_proc_val = pv;
        tick();
        start = 1'b0; cfg_words = 16'($urandom); cfg_mode = 2'($urandom); cfg_proc_val = 8'($urandom);
        chk("busy_after_start", 64'(busy), 64'(1));
        chk("pix_ready_after_start", 64'(pix_ready), 64'(words != 0));
    endtask

    task automatic run_single(input vec_t v);
        logic [7:0] px[4];
        px[0] = v.p0; px[1] = v.p1; px[2] = v.p2; px[3] = v.p3;
        start_frame(1, v.mode, v.proc_val);
        for (int b = 0; b < 4; b++) begin
            pix_valid = 1'b1; pix_in = px[b];
            tick();
        end
        pix_valid = 1'b0;
        chk("single_valid", 64'(slv_data_valid), 64'(1));
        chk("single_data", 64'(slv_data), 64'(v.exp_data));
        chk("single_mode", 64'(slv_mode), 64'(v.mode));
        chk("single_proc", 64'(slv_proc_valid), 64'(v.proc_val));
        slv_ready = 1'b0;
        repeat (3) tick();
        slv_ready = 1'b1;
        tick();
        slv_ready = 1'b0;
        chk("single_xfers", 64'(xfer), 64'(1));
        chk("single_done", 64'(done), 64'(1));
        tick();
        chk("single_busy_clear", 64'(busy), 64'(0));
    endtask

    task automatic run_random(input int words);
        bit got_done = 0;
        start_frame(words, 2'($urandom), 8'($urandom));
        for (int c = 0; c < 600 && !got_done; c++) begin
            pix_valid = 1'($urandom); pix_in = 8'($urandom); slv_ready = 1'($urandom);
            tick();
            if (done) got_done = 1;
        end
        pix_valid = 1'b0; slv_ready = 1'b0;
        chk("frame_timeout", 64'(got_done), 64'(1));
        chk("frame_xfers", 64'(xfer), 64'(words));
        tick();
        chk("frame_busy_clear", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mode: 2'd2, proc_val: 8'h5A, p0: 8'h11, p1: 8'h22, p2: 8'h33, p3: 8'h44, exp_data: 32'h44332211};
        vecs[1] = '{mode: 2'd1, proc_val: 8'hA5, p0: 8'hDE, p1: 8'hAD, p2: 8'hBE, p3: 8'hEF, exp_data: 32'hEFBEADDE};
        vecs[2] = '{mode: 2'd3, proc_val: 8'h00, p0: 8'h00, p1: 8'hFF, p2: 8'h01, p3: 8'h80, exp_data: 32'h8001FF00};
        vecs[3] = '{mode: 2'd0, proc_val: 8'hFF, p0: 8'h7F, p1: 8'h00, p2: 8'h00, p3: 8'h01, exp_data: 32'h0100007F};

        mon_en = 1'b0; xfer = 0; frame_words = 0; pix_acc = 0;
        rst_n = 1'b0; start = 1'b0; cfg_mode = '0; cfg_proc_val = '0; cfg_words = '0;
        pix_in = '0; pix_valid = 1'b0; slv_ready = 1'b0;

        // Reset held with random inputs: all outputs stay zero
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); cfg_words = 16'($urandom_range(1, 4)); cfg_mode = 2'($urandom);
            cfg_proc_val = 8'($urandom); pix_valid = 1'($urandom); pix_in = 8'($urandom);
            slv_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", 64'({pix_ready, slv_data_valid, slv_data, slv_mode, slv_proc_valid, busy, done}), 64'(0));
        end
        start = 1'b0; pix_valid = 1'b0; slv_ready = 1'b0; rst_n = 1'b1;
        mon_en = 1'b1;
        tick();
        chk("idle_after_reset", 64'({busy, pix_ready, slv_data_valid}), 64'(0));

        for (int i = 0; i < 4; i++) run_single(vecs[i]);

        // Zero-length frame: done at cycle 2, busy clear at cycle 3
        start_frame(0, 2'd1, 8'h33);
        chk("zero_done_c1", 64'(done), 64'(0));
        tick();
        chk("zero_done_c2", 64'(done), 64'(1));
        chk("zero_valid_c2", 64'(slv_data_valid), 64'(0));
        tick();
        chk("zero_busy_c3", 64'(busy), 64'(0));
        chk("zero_done_c3", 64'(done), 64'(0));

        run_random(4);
        for (int i = 0; i < 5; i++) run_random($urandom_range(1, 6));

        // Reset mid-frame after two transfers
        start_frame(4, 2'd3, 8'hC3);
        for (int c = 0; c < 400 && xfer < 2; c++) begin
            pix_valid = 1'($urandom); pix_in = 8'($urandom); slv_ready = 1'($urandom);
            tick();
        end
        chk("midreset_two_xfers", 64'(xfer), 64'(2));
        pix_valid = 1'b0; slv_ready = 1'b0; mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("midreset_async", 64'({pix_ready, slv_data_valid, slv_data, slv_mode, slv_proc_valid, busy, done}), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        chk("midreset_idle", 64'({busy, slv_data_valid, done}), 64'(0));
        run_single(vecs[0]);

`ifdef SLV_FEEDER_PREFETCH_EN
        // Both buffers fill under backpressure, then two back-to-back transfers
        start_frame(2, 2'd2, 8'h77);
        slv_ready = 1'b0;
        for (int c = 0; c < 50 && pix_acc < 8; c++) begin
            pix_valid = 1'b1; pix_in = 8'($urandom);
            tick();
        end
        pix_valid = 1'b0;
        chk("pf_pixels", 64'(pix_acc), 64'(8));
        chk("pf_full_ready", 64'(pix_ready), 64'(0));
        chk("pf_valid", 64'(slv_data_valid), 64'(1));
        slv_ready = 1'b1;
        tick();
        chk("pf_b2b_valid", 64'(slv_data_valid), 64'(1));
        chk("pf_first_xfer", 64'(xfer), 64'(1));
        tick();
        slv_ready = 1'b0;
        chk("pf_second_xfer", 64'(xfer), 64'(2));
        chk("pf_done", 64'(done), 64'(1));
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
